// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter for the iomem peripheral bus, with a
// downstream wait watchdog that completes hung transfers with all-ones data.
module iomem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        err,
    output logic        err_master,
    input  logic        err_clr
);
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                s_valid_d;
    logic [DATA_W-1:0]   s_addr_d, s_wdata_d;
    logic [STRB_W-1:0]   s_wstrb_d;
    logic                err_d, err_master_d;
    logic                timeout;
    logic                done;
    logic [DATA_W-1:0]   resp_rdata;

    // Next-state, latch and response logic; ready/rdata are combinational from s_ready.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        s_valid_d    = s_valid;
        s_addr_d     = s_addr;
        s_wdata_d    = s_wdata;
        s_wstrb_d    = s_wstrb;
        err_d        = err;
        err_master_d = err_master;
        m0_ready     = 1'b0;
        m1_ready     = 1'b0;
        m0_rdata     = '0;
        m1_rdata     = '0;
        timeout      = (cnt_q == CNT_W'(TIMEOUT - 1));
        done         = s_ready || timeout;
        resp_rdata   = s_ready ? s_rdata : '1;

        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Contention goes to the master that did not win last time.
                if (m0_valid && (!m1_valid || last_q)) begin
                    state_d   = GRANT0;
                    last_d    = 1'b0;
                    cnt_d     = '0;
                    s_valid_d = 1'b1;
                    s_addr_d  = m0_addr;
                    s_wdata_d = m0_wdata;
                    s_wstrb_d = m0_wstrb;
                end else if (m1_valid) begin
                    state_d   = GRANT1;
                    last_d    = 1'b1;
                    cnt_d     = '0;
                    s_valid_d = 1'b1;
                    s_addr_d  = m1_addr;
                    s_wdata_d = m1_wdata;
                    s_wstrb_d = m1_wstrb;
                end
            end
            GRANT0, GRANT1: begin
                if (done) begin
                    if (state_q == GRANT0) begin
                        m0_ready = 1'b1;
                        m0_rdata = resp_rdata;
                    end else begin
                        m1_ready = 1'b1;
                        m1_rdata = resp_rdata;
                    end
                    state_d   = IDLE;
                    s_valid_d = 1'b0;
                    if (!s_ready) begin
                        err_d        = 1'b1;
                        err_master_d = (state_q == GRANT1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                s_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            s_valid    <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_wstrb    <= '0;
            err        <= 1'b0;
            err_master <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            s_valid    <= s_valid_d;
            s_addr     <= s_addr_d;
            s_wdata    <= s_wdata_d;
            s_wstrb    <= s_wstrb_d;
            err        <= err_d;
            err_master <= err_master_d;
        end
    end
endmodule
